// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion controller: FSM encoding, code width
// and parameter defaults.
package sar_pkg;

    localparam int CODE_W             = 8;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int DEFAULT_TIMEOUT    = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_START    = 2'd1,
        ST_WAIT_EOC = 2'd2,
        ST_CAPTURE  = 2'd3
    } sar_state_e;

endpackage

// File: rtl/sar_code_fifo.sv
// Small synchronous FIFO for captured conversion codes. A push while full is
// accepted only when a pop happens in the same cycle.
module sar_code_fifo
    import sar_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int W     = CODE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          wr_en;
    logic          rd_en;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign rd_en    = pop & ~empty;
    assign wr_en    = push & (~full | rd_en);
    assign pop_data = mem[rd_ptr];

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sar_conv_ctrl.sv
// Periodic SAR conversion sequencer: issues cnvst, waits for eoc with a timeout,
// captures the result and buffers it for a valid/ready consumer.
module sar_conv_ctrl
    import sar_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [7:0]        period,
    input  logic              clr,
    output logic              cnvst,
    input  logic              eoc,
    input  logic [CODE_W-1:0] sar,
    output logic [CODE_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              ovf,
    output logic              tmo,
    output sar_state_e        dbg_state
);

    // Output handshake: a code transfers in every cycle where dout_valid and
    // dout_ready are both high; dout stays stable while dout_valid=1 and dout_ready=0.

    localparam int TW = $clog2(TIMEOUT + 1);

    sar_state_e        state;
    logic [7:0]        pcnt;
    logic [TW-1:0]     tcnt;
    logic [CODE_W-1:0] code_q;
    logic [7:0]        reload;
    logic              push;
    logic              full;
    logic              empty;
    logic              pop;
    logic              drop;
    logic              tmo_hit;

    assign reload  = (period == 8'd0) ? 8'd0 : period - 8'd1;
    assign push    = (state == ST_CAPTURE);
    assign pop     = dout_ready & ~empty;
    assign drop    = push & full & ~pop;
    assign tmo_hit = (state == ST_WAIT_EOC) && !eoc && (tcnt == TW'(TIMEOUT - 1));

    // Period and timeout counters are loaded on the edge entering START so that
    // cnvst pulses land exactly 'period' cycles apart when conversions are short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            pcnt   <= '0;
            tcnt   <= '0;
            code_q <= '0;
            cnvst  <= 1'b0;
            busy   <= 1'b0;
            ovf    <= 1'b0;
            tmo    <= 1'b0;
        end else begin
            cnvst <= 1'b0;
            if (pcnt != 8'd0) begin
                pcnt <= pcnt - 8'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (en && pcnt == 8'd0) begin
                        state <= ST_START;
                        cnvst <= 1'b1;
                        busy  <= 1'b1;
                        pcnt  <= reload;
                        tcnt  <= '0;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT_EOC;
                    tcnt  <= tcnt + TW'(1);
                end
                ST_WAIT_EOC: begin
                    if (eoc) begin
                        state  <= ST_CAPTURE;
                        code_q <= sar;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                        if (tmo_hit) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_CAPTURE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // A set event in the same cycle as clr takes priority.
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr) begin
                ovf <= 1'b0;
            end
            if (tmo_hit) begin
                tmo <= 1'b1;
            end else if (clr) begin
                tmo <= 1'b0;
            end
        end
    end

    sar_code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CODE_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (code_q),
        .pop       (pop),
        .pop_data  (dout),
        .full      (full),
        .empty     (empty)
    );

    assign dout_valid = ~empty;
    assign dbg_state  = state;

endmodule
